// File: rtl/router_pkg.sv
// Shared port numbering for the four-way router and its return-path merger.
// Pure declarations, no timing.
// No flow control in this file.
package router_pkg;
    localparam int NUM_PORTS   = 4;
    localparam int PORT_ADDR_W = 2;

    typedef logic [PORT_ADDR_W-1:0] port_addr_t;
    typedef logic [NUM_PORTS-1:0]   port_vec_t;
endpackage

// File: rtl/rr_arbiter.sv
// Four-way round-robin grant: first requester at or after ptr, wrapping mod 4.
// Latency: purely combinational.
// Backpressure: en low suppresses every grant.
module rr_arbiter
    import router_pkg::*;
(
    input  logic [NUM_PORTS-1:0]   req,
    input  logic [PORT_ADDR_W-1:0] ptr,
    input  logic                   en,
    output logic [NUM_PORTS-1:0]   gnt,
    output logic [PORT_ADDR_W-1:0] gnt_idx,
    output logic                   gnt_any
);

    port_addr_t idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        if (en) begin
            // 2-bit addition gives the wrap 3 -> 0 for free
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = ptr + port_addr_t'(k);
                if (!gnt_any && req[idx]) begin
                    gnt[idx] = 1'b1;
                    gnt_idx  = idx;
                    gnt_any  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/simple_merger.sv
// Four-to-one round-robin merge onto one registered output tagged with source index.
// Latency: 1 cycle from din handshake to dout_valid; one word per cycle sustained.
// Backpressure: din_ready is zero whenever the output register is full and not draining.
module simple_merger
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  din0,
    input  logic [DATA_WIDTH-1:0]  din1,
    input  logic [DATA_WIDTH-1:0]  din2,
    input  logic [DATA_WIDTH-1:0]  din3,
    input  logic [NUM_PORTS-1:0]   din_valid,
    output logic [NUM_PORTS-1:0]   din_ready,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic [PORT_ADDR_W-1:0] dout_addr,
    output logic                   dout_valid,
    input  logic                   dout_ready
);

    port_addr_t            ptr;
    logic                  load;
    logic [NUM_PORTS-1:0]  gnt;
    port_addr_t            gnt_idx;
    logic                  gnt_any;
    logic [DATA_WIDTH-1:0] sel_dat;

    // Reset also blocks grants so no source sees a handshake that would be lost.
    assign load = (!dout_valid || dout_ready) && !reset;

    rr_arbiter u_arb (
        .req     (din_valid),
        .ptr     (ptr),
        .en      (load),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign din_ready = gnt;

    always_comb begin
        sel_dat = din0;
        case (gnt_idx)
            2'd0:    sel_dat = din0;
            2'd1:    sel_dat = din1;
            2'd2:    sel_dat = din2;
            default: sel_dat = din3;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            dout_addr  <= '0;
            dout_valid <= 1'b0;
            ptr        <= '0;
        end else if (gnt_any) begin
            dout       <= sel_dat;
            dout_addr  <= gnt_idx;
            dout_valid <= 1'b1;
            ptr        <= gnt_idx + 2'd1;
        end else if (dout_valid && dout_ready) begin
            // Empty register reads as all zeros, not stale data.
            dout       <= '0;
            dout_addr  <= '0;
            dout_valid <= 1'b0;
        end
    end

endmodule
